unidade_excecao: RTL and testbench
==================================

Name: unidade_excecao

Overview:
- Trap sequencer between the multicycle control unit and the PC/memory datapath of `principal`.
- On an exception request it does four things in order:
  - latches the cause bit and the faulting PC into EPC;
  - reads the handler vector byte from data memory;
  - zero-extends that byte to 64 bits;
  - loads it into PC.
- Holds the control unit stalled (`busy`) for the whole sequence.
- Drives the `saidaEPC` / `fio_UC_causa` observables seen by the top-level simulation.

Parameters:
- `VEC_OPCODE`, 254: byte address of the handler vector for an invalid opcode (cause 0).
- `VEC_OVF`, 255: byte address of the handler vector for an ALU overflow (cause 1).
- `MEM_LAT`, 1: data-memory read latency in cycles, range 1..3.
- `PC_OFFSET`, 4: value subtracted from `pc_atual` to form EPC (PC has already been incremented at fetch).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `exc_opcode` in 1: invalid-opcode request from the control unit (decode state).
- `exc_overflow` in 1: overflow request from the control unit (execute state).
- `pc_atual` in 64: current PC register value.
- `mem_rdata` in 64: data-memory read data.
- `busy` out 1: sequence in progress; the control unit must freeze.
- `epc` out 64: EPC register.
- `causa` out 1: cause register; 0 = opcode, 1 = overflow.
- `mem_addr` out 64: data-memory address while fetching the vector.
- `mem_rd` out 1: data-memory read strobe, with the write strobe held low.
- `pc_load` out 1: one-cycle PC write enable.
- `pc_next` out 64: value written to PC when `pc_load` = 1.
- `done` out 1: one-cycle pulse on sequence completion.

Behaviour:
- Reset (synchronous): `state` = IDLE. All outputs are 0: `epc`, `causa`, `mem_addr`, `mem_rd`, `pc_load`, `pc_next`, `busy`, `done`, wait counter. A reset in any state aborts the sequence, and no `pc_load` is issued afterwards.
- States: IDLE → SAVE → READ → WAIT → LOAD → IDLE.
- IDLE:
  - If `exc_opcode` or `exc_overflow` is high, go to SAVE.
  - Both high in the same cycle: opcode wins, `causa` = 0.
  - `busy` = 0.
- SAVE (1 cycle):
  - `epc` <= `pc_atual` − `PC_OFFSET`, using 64-bit modular arithmetic; `pc_atual` = 0 gives 0xFFFF_FFFF_FFFF_FFFC.
  - `causa` <= selected cause.
  - `busy` = 1.
- READ (1 cycle):
  - `mem_addr` = `VEC_OPCODE` if `causa` = 0, else `VEC_OVF`.
  - `mem_rd` = 1.
  - Wait counter <= `MEM_LAT` − 1.
- WAIT:
  - `mem_addr` is held and `mem_rd` = 0.
  - Stay while the counter ≠ 0, decrementing each cycle.
  - The total cycles spent in READ plus WAIT equals `MEM_LAT` + 1.
- LOAD (1 cycle):
  - `pc_next` = {56'b0, `mem_rdata[7:0]`}; the upper 56 bits of `mem_rdata` are ignored.
  - `pc_load` = 1 and `done` = 1.
  - Next state is IDLE, where `busy` drops.
- Requests while `busy`: ignored and not queued. `epc` and `causa` are not overwritten.
- `epc` and `causa` hold their values until the next SAVE or reset.
- Latency: from request sampled in IDLE to `pc_load` is `MEM_LAT` + 3 cycles; this is 4 for the default `MEM_LAT` = 1.
- Outputs are registered per state (Moore). `pc_next` is combinational from `mem_rdata` only in LOAD, and is 0 otherwise.

Optional Feature:
- Macro name: `UNIDADE_EXCECAO_ERET_EN`.
- When defined:
  - Adds input port `eret` (1 bit).
  - In IDLE with no exception request, `eret` = 1 causes a one-cycle `pc_load` = 1 with `pc_next` = `epc`; `busy` stays 0 and there is no state change.
  - An exception request in the same cycle takes priority over `eret`, and the `eret` is dropped.
- When undefined: no `eret` port, and the PC can only be redirected by the trap sequence.

Decomposition:
- Shared package `excecao_pkg` contains:
  - enum `estado_exc_t` {IDLE, SAVE, READ, WAIT, LOAD};
  - constants `CAUSA_OPCODE` = 1'b0 and `CAUSA_OVF` = 1'b1;
  - default vector addresses 254 and 255.
- No sub-module. The wait counter is inline.

Test Plan:
- Reset: hold `reset` = 1 for 2 cycles with `exc_opcode` = 1 → all outputs 0 and `state` = IDLE throughout.
- Opcode trap, `MEM_LAT` = 1: `pc_atual` = 0x108, pulse `exc_opcode`, memory returns 0x..._00AB at address 254 → `epc` = 0x104, `causa` = 0, `mem_addr` = 254, `pc_load` with `pc_next` = 0xAB exactly 4 cycles after the request, `busy` high for 4 cycles.
- Simultaneous requests: `exc_opcode` = `exc_overflow` = 1 → `causa` = 0, `mem_addr` = 254.
- Overflow trap, `MEM_LAT` = 3: `pc_atual` = 0x0, memory byte at 255 = 0x40 → `epc` = 0xFFFF_FFFF_FFFF_FFFC, `causa` = 1, `pc_load` 6 cycles after the request with `pc_next` = 0x40.
- Busy request and mid-sequence reset:
  - a second `exc_overflow` arriving during WAIT is ignored, and `causa` keeps its first value;
  - a reset asserted in WAIT → no `pc_load`, and `epc` = 0 the next cycle.
- With `UNIDADE_EXCECAO_ERET_EN`: after the opcode trap above, pulse `eret` → single-cycle `pc_load` with `pc_next` = 0x104 and `busy` = 0.

Source files
------------

// File: rtl/unidade_excecao_pkg.sv
// Shared types and constants for the trap sequencer (package excecao_pkg).
package excecao_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SAVE = 3'd1,
    READ = 3'd2,
    WAIT = 3'd3,
    LOAD = 3'd4
  } estado_exc_t;

  localparam logic CAUSA_OPCODE = 1'b0;
  localparam logic CAUSA_OVF    = 1'b1;

  localparam logic [63:0] VEC_OPCODE_DEF = 64'd254;
  localparam logic [63:0] VEC_OVF_DEF    = 64'd255;

  function automatic logic [63:0] zext_byte(input logic [7:0] b);
    return {56'd0, b};
  endfunction

endpackage

// File: rtl/unidade_excecao.sv
// Trap sequencer: saves EPC/cause, fetches the handler vector byte, loads PC.
// Optional return-from-exception port enabled by macro UNIDADE_EXCECAO_ERET_EN.
module unidade_excecao
  import excecao_pkg::*;
#(
  parameter logic [63:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [63:0] VEC_OVF    = VEC_OVF_DEF,
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [63:0] PC_OFFSET  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef UNIDADE_EXCECAO_ERET_EN
  input  logic        eret,
`endif
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic [63:0] pc_atual,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic [63:0] epc,
  output logic        causa,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        pc_load,
  output logic [63:0] pc_next,
  output logic        done
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  estado_exc_t state_r;
  logic        cause_sel_r;
  logic [63:0] epc_r;
  logic        causa_r;
  logic [63:0] mem_addr_r;
  logic        mem_rd_r;
  logic        pc_load_r;
  logic        done_r;
  logic        busy_r;
  logic [1:0]  cnt_r;
  logic [63:0] pc_next_s;
`ifdef UNIDADE_EXCECAO_ERET_EN
  logic        eret_load_r;
`endif

  // Only the low byte of the vector word is meaningful.
  logic unused_s;
  assign unused_s = ^mem_rdata[63:8];

  // Sequencer state and all registered (Moore) outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cause_sel_r <= CAUSA_OPCODE;
      epc_r       <= 64'd0;
      causa_r     <= CAUSA_OPCODE;
      mem_addr_r  <= 64'd0;
      mem_rd_r    <= 1'b0;
      pc_load_r   <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      cnt_r       <= 2'd0;
`ifdef UNIDADE_EXCECAO_ERET_EN
      eret_load_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          pc_load_r <= 1'b0;
          done_r    <= 1'b0;
`ifdef UNIDADE_EXCECAO_ERET_EN
          eret_load_r <= 1'b0;
`endif
          if (exc_opcode || exc_overflow) begin
            // Opcode request wins when both arrive together.
            state_r     <= SAVE;
            busy_r      <= 1'b1;
            cause_sel_r <= exc_opcode ? CAUSA_OPCODE : CAUSA_OVF;
          end
`ifdef UNIDADE_EXCECAO_ERET_EN
          else if (eret) begin
            pc_load_r   <= 1'b1;
            eret_load_r <= 1'b1;
          end
`endif
          else begin
            state_r <= IDLE;
          end
        end
        SAVE: begin
          epc_r      <= pc_atual - PC_OFFSET;
          causa_r    <= cause_sel_r;
          mem_addr_r <= (cause_sel_r == CAUSA_OPCODE) ? VEC_OPCODE : VEC_OVF;
          mem_rd_r   <= 1'b1;
          state_r    <= READ;
        end
        READ: begin
          mem_rd_r <= 1'b0;
          cnt_r    <= LAT_INIT;
          state_r  <= WAIT;
        end
        WAIT: begin
          if (cnt_r != 2'd0) begin
            cnt_r <= cnt_r - 2'd1;
          end else begin
            state_r    <= LOAD;
            pc_load_r  <= 1'b1;
            done_r     <= 1'b1;
            mem_addr_r <= 64'd0;
          end
        end
        LOAD: begin
          state_r   <= IDLE;
          pc_load_r <= 1'b0;
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          mem_rd_r   <= 1'b0;
          mem_addr_r <= 64'd0;
          pc_load_r  <= 1'b0;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          cnt_r      <= 2'd0;
        end
      endcase
    end
  end

  // PC redirect value: vector byte in LOAD, saved EPC on a return.
  always_comb begin
    pc_next_s = 64'd0;
    if (state_r == LOAD) begin
      pc_next_s = zext_byte(mem_rdata[7:0]);
    end
`ifdef UNIDADE_EXCECAO_ERET_EN
    else if (eret_load_r) begin
      pc_next_s = epc_r;
    end
`endif
    else begin
      pc_next_s = 64'd0;
    end
  end

  assign busy     = busy_r;
  assign epc      = epc_r;
  assign causa    = causa_r;
  assign mem_addr = mem_addr_r;
  assign mem_rd   = mem_rd_r;
  assign pc_load  = pc_load_r;
  assign pc_next  = pc_next_s;
  assign done     = done_r;

endmodule

// File: tb/tb_unidade_excecao.sv
// Scoreboard bench for unidade_excecao: two instances (MEM_LAT 1 and 3) share stimulus.
module tb_unidade_excecao;
  import excecao_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_opcode = 1'b0;
  logic        exc_overflow = 1'b0;
  logic [63:0] pc_atual = 64'd0;
`ifdef UNIDADE_EXCECAO_ERET_EN
  logic        eret = 1'b0;
`endif
  logic [63:0] rdata1 = 64'd0, rdata3 = 64'd0;
  logic        busy1, causa1, mem_rd1, pc_load1, done1;
  logic [63:0] epc1, mem_addr1, pc_next1;
  logic        busy3, causa3, mem_rd3, pc_load3, done3;
  logic [63:0] epc3, mem_addr3, pc_next3;

  always #5 clk = ~clk;

  unidade_excecao #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
`ifdef UNIDADE_EXCECAO_ERET_EN
    .eret(eret),
`endif
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .pc_atual(pc_atual),
    .mem_rdata(rdata1), .busy(busy1), .epc(epc1), .causa(causa1),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .pc_load(pc_load1),
    .pc_next(pc_next1), .done(done1));

  unidade_excecao #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
`ifdef UNIDADE_EXCECAO_ERET_EN
    .eret(eret),
`endif
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .pc_atual(pc_atual),
    .mem_rdata(rdata3), .busy(busy3), .epc(epc3), .causa(causa3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .pc_load(pc_load3),
    .pc_next(pc_next3), .done(done3));

  typedef struct {
    logic [63:0] pc_next;
    logic [63:0] epc;
    logic [63:0] addr;
    logic        causa;
    logic        is_eret;
    int          lat;
    int          req_cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int brun1 = 0;
  int brun3 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_lookup(input logic [63:0] a);
    if (a == 64'd254) return 64'hDEAD_BEEF_0000_00AB;
    else if (a == 64'd255) return 64'h0123_4567_89AB_CD40;
    else return 64'hEEEE_EEEE_EEEE_EEEE;
  endfunction

  // Vector memory: read data latched on the strobe and held.
  always @(posedge clk) begin
    if (mem_rd1) rdata1 <= mem_lookup(mem_addr1);
    if (mem_rd3) rdata3 <= mem_lookup(mem_addr3);
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic mon_step(input int k, input logic busy, input logic mem_rd,
                          input logic pc_load, input logic done, input logic causa,
                          input logic [63:0] mem_addr, input logic [63:0] epc,
                          input logic [63:0] pc_next, input int brun);
    exp_t e;
    int   n;
    string t;
    t = (k == 1) ? "L1" : "L3";
    n = (k == 1) ? q1.size() : q3.size();
    if (mem_rd) begin
      if (n == 0) check64({t, "_unexpected_mem_rd"}, 64'd1, 64'd0);
      else begin
        e = (k == 1) ? q1[0] : q3[0];
        check64({t, "_mem_addr"}, mem_addr, e.addr);
      end
    end
    if (pc_load) begin
      if (n == 0) check64({t, "_unexpected_pc_load"}, 64'd1, 64'd0);
      else begin
        if (k == 1) e = q1.pop_front();
        else e = q3.pop_front();
        check64({t, "_pc_next"}, pc_next, e.pc_next);
        check64({t, "_epc"}, epc, e.epc);
        check64({t, "_causa"}, {63'd0, causa}, {63'd0, e.causa});
        check64({t, "_latency"}, 64'(cyc - e.req_cyc), 64'(e.lat));
        check64({t, "_busy_at_load"}, {63'd0, busy}, {63'd0, ~e.is_eret});
        check64({t, "_done"}, {63'd0, done}, {63'd0, ~e.is_eret});
        if (!e.is_eret) check64({t, "_busy_cycles"}, 64'(brun), 64'(e.lat));
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a PC load is presented.
  always @(negedge clk) begin
    brun1 = busy1 ? brun1 + 1 : 0;
    brun3 = busy3 ? brun3 + 1 : 0;
    mon_step(1, busy1, mem_rd1, pc_load1, done1, causa1, mem_addr1, epc1, pc_next1, brun1);
    mon_step(3, busy3, mem_rd3, pc_load3, done3, causa3, mem_addr3, epc3, pc_next3, brun3);
  end

  task automatic push_exp(input logic [63:0] pcn, input logic [63:0] ep,
                          input logic [63:0] addr, input logic c, input logic er);
    exp_t e;
    e.pc_next = pcn; e.epc = ep; e.addr = addr; e.causa = c; e.is_eret = er;
    e.req_cyc = cyc;
    e.lat = er ? 1 : 4;
    q1.push_back(e);
    e.lat = er ? 1 : 6;
    q3.push_back(e);
  endtask

  task automatic trap(input logic op, input logic ov, input logic [63:0] pc,
                      input logic [63:0] pcn, input logic [63:0] ep,
                      input logic [63:0] addr, input logic c);
    @(posedge clk); #1;
    exc_opcode = op; exc_overflow = ov; pc_atual = pc;
    push_exp(pcn, ep, addr, c, 1'b0);
    @(posedge clk); #1;
    exc_opcode = 1'b0; exc_overflow = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q3.size() == 0) break;
    end
    @(negedge clk);
    check64("scoreboard_drain_timeout", 64'(q1.size() + q3.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string t);
    check64({t, "_busy"}, {62'd0, busy1, busy3}, 64'd0);
    check64({t, "_epc1"}, epc1, 64'd0);
    check64({t, "_epc3"}, epc3, 64'd0);
    check64({t, "_causa"}, {62'd0, causa1, causa3}, 64'd0);
    check64({t, "_mem_addr1"}, mem_addr1, 64'd0);
    check64({t, "_mem_addr3"}, mem_addr3, 64'd0);
    check64({t, "_strobes"}, {58'd0, mem_rd1, mem_rd3, pc_load1, pc_load3, done1, done3}, 64'd0);
    check64({t, "_pc_next1"}, pc_next1, 64'd0);
    check64({t, "_pc_next3"}, pc_next3, 64'd0);
  endtask

  initial begin
    // Reset held two cycles with a pending opcode request.
    exc_opcode = 1'b1;
    @(posedge clk); @(negedge clk); check_all_zero("reset_c1");
    @(posedge clk); @(negedge clk); check_all_zero("reset_c2");
    @(posedge clk); #1;
    reset = 1'b0; exc_opcode = 1'b0;

    trap(1'b1, 1'b0, 64'h108, 64'hAB, 64'h104, 64'd254, 1'b0);
    wait_idle();

`ifdef UNIDADE_EXCECAO_ERET_EN
    @(posedge clk); #1;
    eret = 1'b1;
    push_exp(64'h104, 64'h104, 64'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    eret = 1'b0;
    wait_idle();
`endif

    trap(1'b1, 1'b1, 64'h2000, 64'hAB, 64'h1FFC, 64'd254, 1'b0);
    wait_idle();

    trap(1'b0, 1'b1, 64'h0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFC, 64'd255, 1'b1);
    wait_idle();

    // Overflow request arriving during WAIT must be dropped.
    trap(1'b1, 1'b0, 64'h300, 64'hAB, 64'h2FC, 64'd254, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    exc_overflow = 1'b1;
    @(posedge clk); #1;
    exc_overflow = 1'b0;
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      check64("ignored_req_busy", {62'd0, busy1, busy3}, 64'd0);
    end
    check64("ignored_req_causa", {62'd0, causa1, causa3}, 64'd0);
    check64("ignored_req_epc3", epc3, 64'h2FC);

    // Reset in WAIT aborts the sequence: no PC load afterwards.
    trap(1'b0, 1'b1, 64'h500, 64'h40, 64'h4FC, 64'd255, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    q1.delete();
    q3.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check64("abort_epc1", epc1, 64'd0);
    check64("abort_epc3", epc3, 64'd0);
    check64("abort_busy", {62'd0, busy1, busy3}, 64'd0);
    repeat (10) @(negedge clk);
    check64("abort_idle_busy", {62'd0, busy1, busy3}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
